// File: rtl/cgra_imem_responder.sv
// Arbitrates controller and host onto the single-port config SRAM; grant is combinational, response 1 cycle later.
// No backpressure on responses; the host wins after HOST_WAIT_MAX refused cycles so neither side starves.
package cgra_pkg;
    localparam int IMEM_WIDTH        = 32;
    localparam int IMEM_N_LINES_LOG2 = 6;
endpackage

module cgra_imem_responder
    import cgra_pkg::*;
#(
    parameter int unsigned HOST_WAIT_MAX = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         ctrl_req_i,
    input  logic [IMEM_N_LINES_LOG2-1:0] ctrl_radd_i,
    output logic                         ctrl_gnt_o,
    output logic                         ctrl_rvalid_o,
    output logic [IMEM_WIDTH-1:0]        ctrl_rdata_o,
    input  logic                         host_req_i,
    input  logic                         host_we_i,
    input  logic [IMEM_N_LINES_LOG2-1:0] host_addr_i,
    input  logic [IMEM_WIDTH-1:0]        host_wdata_i,
    output logic                         host_gnt_o,
    output logic                         host_rvalid_o,
    output logic [IMEM_WIDTH-1:0]        host_rdata_o,
    output logic                         sram_req_o,
    output logic                         sram_we_o,
    output logic [IMEM_N_LINES_LOG2-1:0] sram_addr_o,
    output logic [IMEM_WIDTH-1:0]        sram_wdata_o,
    input  logic [IMEM_WIDTH-1:0]        sram_rdata_i
);

    localparam logic [3:0] WAIT_MAX = 4'(HOST_WAIT_MAX);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CTRL = 2'd1,
        OWN_HOST = 2'd2
    } owner_t;

    owner_t     state_q, state_d;
    logic [3:0] host_wait_cnt, host_wait_cnt_d;
    logic       we_q;
    logic       starve;

    // Arbitration sees only request inputs and the wait counter, never SRAM data.
    assign starve = host_req_i && (host_wait_cnt == WAIT_MAX);

    always_comb begin
        ctrl_gnt_o = ctrl_req_i && !starve;
        host_gnt_o = host_req_i && (!ctrl_req_i || starve);
    end

    always_comb begin
        host_wait_cnt_d = host_wait_cnt;
        if (!host_req_i || host_gnt_o) begin
            host_wait_cnt_d = 4'd0;
        end else if (host_wait_cnt != WAIT_MAX) begin
            host_wait_cnt_d = host_wait_cnt + 4'd1;
        end
    end

    always_comb begin
        sram_req_o   = ctrl_gnt_o | host_gnt_o;
        sram_we_o    = host_gnt_o & host_we_i;
        sram_addr_o  = '0;
        sram_wdata_o = '0;
        if (host_gnt_o) begin
            sram_addr_o  = host_addr_i;
            sram_wdata_o = host_wdata_i;
        end else if (ctrl_gnt_o) begin
            sram_addr_o  = ctrl_radd_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= OWN_NONE;
            host_wait_cnt <= 4'd0;
            we_q          <= 1'b0;
        end else begin
            state_q       <= state_d;
            host_wait_cnt <= host_wait_cnt_d;
            we_q          <= host_gnt_o & host_we_i;
        end
    end

    always_comb begin
        state_d = OWN_NONE;
        if (host_gnt_o) begin
            state_d = OWN_HOST;
        end else if (ctrl_gnt_o) begin
            state_d = OWN_CTRL;
        end
    end

    // Write responses carry zero data; rdata is forced low whenever rvalid is low.
    always_comb begin
        ctrl_rvalid_o = 1'b0;
        ctrl_rdata_o  = '0;
        host_rvalid_o = 1'b0;
        host_rdata_o  = '0;
        case (state_q)
            OWN_CTRL: begin
                ctrl_rvalid_o = 1'b1;
                ctrl_rdata_o  = sram_rdata_i;
            end
            OWN_HOST: begin
                host_rvalid_o = 1'b1;
                host_rdata_o  = we_q ? '0 : sram_rdata_i;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cgra_imem_responder.sv
// Directed vector table plus multi-cycle sequences for the instruction-memory responder.
module tb_cgra_imem_responder;
    import cgra_pkg::*;

    logic                         clk_i = 1'b0;
    logic                         rst_ni;
    logic                         ctrl_req_i;
    logic [IMEM_N_LINES_LOG2-1:0] ctrl_radd_i;
    logic                         ctrl_gnt_o, ctrl_rvalid_o;
    logic [IMEM_WIDTH-1:0]        ctrl_rdata_o;
    logic                         host_req_i, host_we_i;
    logic [IMEM_N_LINES_LOG2-1:0] host_addr_i;
    logic [IMEM_WIDTH-1:0]        host_wdata_i;
    logic                         host_gnt_o, host_rvalid_o;
    logic [IMEM_WIDTH-1:0]        host_rdata_o;
    logic                         sram_req_o, sram_we_o;
    logic [IMEM_N_LINES_LOG2-1:0] sram_addr_o;
    logic [IMEM_WIDTH-1:0]        sram_wdata_o;
    logic [IMEM_WIDTH-1:0]        sram_rdata_i;

    logic [IMEM_WIDTH-1:0] mem [2**IMEM_N_LINES_LOG2];

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    cgra_imem_responder #(.HOST_WAIT_MAX(4)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .ctrl_req_i(ctrl_req_i), .ctrl_radd_i(ctrl_radd_i), .ctrl_gnt_o(ctrl_gnt_o),
        .ctrl_rvalid_o(ctrl_rvalid_o), .ctrl_rdata_o(ctrl_rdata_o),
        .host_req_i(host_req_i), .host_we_i(host_we_i), .host_addr_i(host_addr_i),
        .host_wdata_i(host_wdata_i), .host_gnt_o(host_gnt_o), .host_rvalid_o(host_rvalid_o),
        .host_rdata_o(host_rdata_o),
        .sram_req_o(sram_req_o), .sram_we_o(sram_we_o), .sram_addr_o(sram_addr_o),
        .sram_wdata_o(sram_wdata_o), .sram_rdata_i(sram_rdata_i)
    );

    // Single-port SRAM with 1-cycle read latency.
    always @(posedge clk_i) begin
        if (sram_req_o) begin
            if (sram_we_o) mem[sram_addr_o] <= sram_wdata_o;
            else           sram_rdata_i <= mem[sram_addr_o];
        end
    end

    typedef struct {
        logic        c_req;
        logic [5:0]  c_addr;
        logic        h_req;
        logic        h_we;
        logic [5:0]  h_addr;
        logic [31:0] h_wdata;
        logic        e_cg;
        logic        e_hg;
        logic        e_crv;
        logic [31:0] e_crd;
        logic        e_hrv;
        logic [31:0] e_hrd;
        logic        e_swe;
        logic [5:0]  e_saddr;
        logic [31:0] e_swd;
    } vec_t;

    vec_t vecs [14];

    function automatic vec_t mk(logic c_req, logic [5:0] c_addr, logic h_req, logic h_we,
                                logic [5:0] h_addr, logic [31:0] h_wdata,
                                logic e_cg, logic e_hg, logic e_crv, logic [31:0] e_crd,
                                logic e_hrv, logic [31:0] e_hrd, logic e_swe,
                                logic [5:0] e_saddr, logic [31:0] e_swd);
        vec_t v;
        v.c_req = c_req; v.c_addr = c_addr; v.h_req = h_req; v.h_we = h_we;
        v.h_addr = h_addr; v.h_wdata = h_wdata; v.e_cg = e_cg; v.e_hg = e_hg;
        v.e_crv = e_crv; v.e_crd = e_crd; v.e_hrv = e_hrv; v.e_hrd = e_hrd;
        v.e_swe = e_swe; v.e_saddr = e_saddr; v.e_swd = e_swd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic c_req, input logic [5:0] c_addr, input logic h_req,
                         input logic h_we, input logic [5:0] h_addr, input logic [31:0] h_wdata);
        ctrl_req_i = c_req; ctrl_radd_i = c_addr;
        host_req_i = h_req; host_we_i = h_we; host_addr_i = h_addr; host_wdata_i = h_wdata;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " ctrl_gnt"}, 32'(ctrl_gnt_o), 0);
        chk({tag, " host_gnt"}, 32'(host_gnt_o), 0);
        chk({tag, " ctrl_rvalid"}, 32'(ctrl_rvalid_o), 0);
        chk({tag, " host_rvalid"}, 32'(host_rvalid_o), 0);
        chk({tag, " ctrl_rdata"}, ctrl_rdata_o, 0);
        chk({tag, " host_rdata"}, host_rdata_o, 0);
        chk({tag, " sram_req"}, 32'(sram_req_o), 0);
        chk({tag, " sram_addr"}, 32'(sram_addr_o), 0);
    endtask

    initial begin
        logic cg_prev, hg_prev, exp_h;
        for (int i = 0; i < 64; i++) mem[i] = 32'(i);
        sram_rdata_i = '0;
        rst_ni = 1'b0;
        drive(0, 0, 0, 0, 0, 0);

        //            creq cadr  hreq hwe hadr hwdata     cg hg crv crd    hrv hrd        swe sadr  swd
        vecs[0]  = mk(0, 6'h00, 0, 0, 6'h00, 32'h0,     0, 0, 0, 32'h0,  0, 32'h0,     0, 6'h00, 32'h0);
        vecs[1]  = mk(1, 6'h10, 0, 0, 6'h00, 32'h0,     1, 0, 0, 32'h0,  0, 32'h0,     0, 6'h10, 32'h0);
        vecs[2]  = mk(1, 6'h11, 0, 0, 6'h00, 32'h0,     1, 0, 1, 32'h10, 0, 32'h0,     0, 6'h11, 32'h0);
        vecs[3]  = mk(1, 6'h12, 0, 0, 6'h00, 32'h0,     1, 0, 1, 32'h11, 0, 32'h0,     0, 6'h12, 32'h0);
        vecs[4]  = mk(1, 6'h13, 0, 0, 6'h00, 32'h0,     1, 0, 1, 32'h12, 0, 32'h0,     0, 6'h13, 32'h0);
        vecs[5]  = mk(0, 6'h00, 0, 0, 6'h00, 32'h0,     0, 0, 1, 32'h13, 0, 32'h0,     0, 6'h00, 32'h0);
        vecs[6]  = mk(0, 6'h00, 1, 1, 6'h03, 32'hA5A5,  0, 1, 0, 32'h0,  0, 32'h0,     1, 6'h03, 32'hA5A5);
        vecs[7]  = mk(0, 6'h00, 1, 0, 6'h03, 32'h0,     0, 1, 0, 32'h0,  1, 32'h0,     0, 6'h03, 32'h0);
        vecs[8]  = mk(0, 6'h00, 0, 0, 6'h00, 32'h0,     0, 0, 0, 32'h0,  1, 32'hA5A5,  0, 6'h00, 32'h0);
        vecs[9]  = mk(1, 6'h21, 1, 0, 6'h20, 32'h0,     1, 0, 0, 32'h0,  0, 32'h0,     0, 6'h21, 32'h0);
        vecs[10] = mk(0, 6'h00, 0, 0, 6'h00, 32'h0,     0, 0, 1, 32'h21, 0, 32'h0,     0, 6'h00, 32'h0);
        vecs[11] = mk(0, 6'h00, 1, 0, 6'h05, 32'h0,     0, 1, 0, 32'h0,  0, 32'h0,     0, 6'h05, 32'h0);
        vecs[12] = mk(0, 6'h00, 1, 0, 6'h06, 32'h0,     0, 1, 0, 32'h0,  1, 32'h5,     0, 6'h06, 32'h0);
        vecs[13] = mk(0, 6'h00, 0, 0, 6'h00, 32'h0,     0, 0, 0, 32'h0,  1, 32'h6,     0, 6'h00, 32'h0);

        repeat (2) @(negedge clk_i);
        #2 chk_all_zero("in_reset");
        @(negedge clk_i);
        rst_ni = 1'b1;

        foreach (vecs[i]) begin
            if (i != 0) @(negedge clk_i);
            drive(vecs[i].c_req, vecs[i].c_addr, vecs[i].h_req, vecs[i].h_we,
                  vecs[i].h_addr, vecs[i].h_wdata);
            #2;
            chk($sformatf("v%0d ctrl_gnt", i), 32'(ctrl_gnt_o), 32'(vecs[i].e_cg));
            chk($sformatf("v%0d host_gnt", i), 32'(host_gnt_o), 32'(vecs[i].e_hg));
            chk($sformatf("v%0d ctrl_rvalid", i), 32'(ctrl_rvalid_o), 32'(vecs[i].e_crv));
            chk($sformatf("v%0d ctrl_rdata", i), ctrl_rdata_o, vecs[i].e_crd);
            chk($sformatf("v%0d host_rvalid", i), 32'(host_rvalid_o), 32'(vecs[i].e_hrv));
            chk($sformatf("v%0d host_rdata", i), host_rdata_o, vecs[i].e_hrd);
            chk($sformatf("v%0d sram_req", i), 32'(sram_req_o), 32'(vecs[i].e_cg | vecs[i].e_hg));
            chk($sformatf("v%0d sram_we", i), 32'(sram_we_o), 32'(vecs[i].e_swe));
            chk($sformatf("v%0d sram_addr", i), 32'(sram_addr_o), 32'(vecs[i].e_saddr));
            chk($sformatf("v%0d sram_wdata", i), sram_wdata_o, vecs[i].e_swd);
        end

        // Starvation: both requesting continuously; host wins every 5th cycle.
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk_i);
            drive(1, 6'h2A, 1, 0, 6'h15, 0);
            #2;
            exp_h = (k % 5 == 0);
            chk($sformatf("starve c%0d host_gnt", k), 32'(host_gnt_o), 32'(exp_h));
            chk($sformatf("starve c%0d ctrl_gnt", k), 32'(ctrl_gnt_o), 32'(!exp_h));
            chk($sformatf("starve c%0d sram_addr", k), 32'(sram_addr_o), exp_h ? 32'h15 : 32'h2A);
        end
        @(negedge clk_i);
        drive(0, 0, 0, 0, 0, 0);

        // Host-only traffic never accumulates wait count.
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_i);
            drive(0, 0, 1, 0, 6'(k + 1), 0);
            #2;
            chk($sformatf("hostonly c%0d host_gnt", k), 32'(host_gnt_o), 1);
            chk($sformatf("hostonly c%0d wait_cnt", k), 32'(dut.host_wait_cnt), 0);
        end
        @(negedge clk_i);
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk_i);

        // Reset mid-access: response to the granted read must be dropped.
        drive(1, 6'h12, 0, 0, 0, 0);
        #2 chk("rst_mid gnt", 32'(ctrl_gnt_o), 1);
        @(negedge clk_i);
        drive(0, 0, 0, 0, 0, 0);
        rst_ni = 1'b0;
        #1;
        chk("rst_mid ctrl_rvalid", 32'(ctrl_rvalid_o), 0);
        chk("rst_mid ctrl_rdata", ctrl_rdata_o, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #2;
            chk($sformatf("post_rst c%0d ctrl_rvalid", k), 32'(ctrl_rvalid_o), 0);
            chk($sformatf("post_rst c%0d host_rvalid", k), 32'(host_rvalid_o), 0);
            @(negedge clk_i);
        end

        // Random traffic: exclusive grants, each matched by exactly one rvalid next cycle.
        cg_prev = 1'b0;
        hg_prev = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk_i);
            #1;
            chk("rnd ctrl_rvalid", 32'(ctrl_rvalid_o), 32'(cg_prev));
            chk("rnd host_rvalid", 32'(host_rvalid_o), 32'(hg_prev));
            drive(1'($urandom_range(1)), 6'($urandom), 1'($urandom_range(1)),
                  1'($urandom_range(1)), 6'($urandom), $urandom);
            #1;
            chk("rnd gnt_exclusive", 32'(ctrl_gnt_o & host_gnt_o), 0);
            cg_prev = ctrl_gnt_o;
            hg_prev = host_gnt_o;
        end
        @(negedge clk_i);
        drive(0, 0, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/cgra_imem_responder.md
CGRA_IMEM_RESPONDER -- requirements
Module: cgra_imem_responder

Interface
REQ-001 SHALL take parameter HOST_WAIT_MAX, default 4, meaning the number of consecutive refused host cycles after which the host wins arbitration (legal range 1..15).
REQ-002 SHALL take data width IMEM_WIDTH and address width IMEM_N_LINES_LOG2 from cgra_pkg.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock.
REQ-004 SHALL have port rst_ni, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port ctrl_req_i, input, 1 bit: configuration-word read request from the CGRA controller.
REQ-006 SHALL have port ctrl_radd_i, input, IMEM_N_LINES_LOG2 bits: controller read address.
REQ-007 SHALL have port ctrl_gnt_o, output, 1 bit: controller request accepted this cycle.
REQ-008 SHALL have port ctrl_rvalid_o, output, 1 bit: controller read data valid.
REQ-009 SHALL have port ctrl_rdata_o, output, IMEM_WIDTH bits: configuration word broadcast to the RCS columns.
REQ-010 SHALL have ports host_req_i (input, 1), host_we_i (input, 1), host_addr_i (input, IMEM_N_LINES_LOG2) and host_wdata_i (input, IMEM_WIDTH): the host bus request.
REQ-011 SHALL have ports host_gnt_o (output, 1), host_rvalid_o (output, 1) and host_rdata_o (output, IMEM_WIDTH): the host bus response.
REQ-012 SHALL have ports sram_req_o (output, 1), sram_we_o (output, 1), sram_addr_o (output, IMEM_N_LINES_LOG2), sram_wdata_o (output, IMEM_WIDTH) and sram_rdata_i (input, IMEM_WIDTH): the SRAM macro, which has 1-cycle read latency.

Function
REQ-013 SHALL compute grants combinationally in the same cycle as the request; at most one of ctrl_gnt_o and host_gnt_o is high in any cycle.
REQ-014 SHALL apply this default priority: the controller wins when ctrl_req_i=1 and the starvation condition (REQ-016) is false.
REQ-015 SHALL grant the host when host_req_i=1 and either ctrl_req_i=0 or the starvation condition is true.
REQ-016 SHALL define the starvation condition as host_wait_cnt == HOST_WAIT_MAX and host_req_i=1.
REQ-017 SHALL keep host_wait_cnt as a 4-bit counter with this update rule:
- increment when host_req_i=1 and host_gnt_o=0;
- clear on host grant or when host_req_i=0;
- saturate at HOST_WAIT_MAX, never wrap.
REQ-018 SHALL drive the SRAM from the granted port in the grant cycle:
- sram_req_o = ctrl_gnt_o | host_gnt_o;
- sram_addr_o and sram_wdata_o from the granted port;
- sram_we_o = host_gnt_o & host_we_i (the controller never writes).
REQ-019 SHALL drive sram_addr_o, sram_wdata_o and sram_we_o to zero when no grant is given.
REQ-020 SHALL register a response owner tag (NONE/CTRL/HOST) on every grant; this is the response FSM, with next state = owner of the current-cycle grant, else NONE.
REQ-021 SHALL, in state CTRL, assert ctrl_rvalid_o=1 with ctrl_rdata_o=sram_rdata_i, exactly 1 cycle after ctrl_gnt_o.
REQ-022 SHALL, in state HOST, assert host_rvalid_o=1 exactly 1 cycle after host_gnt_o, for both reads and writes.
REQ-023 SHALL set host_rdata_o=sram_rdata_i for host reads and host_rdata_o=0 for host writes; a registered we flag selects between them.
REQ-024 SHALL hold each rdata output at zero whenever its rvalid is low.
REQ-025 SHALL sustain back-to-back grants on every cycle with no bubbles: throughput 1 access/cycle, latency 1 cycle.
REQ-026 SHALL, on simultaneous requests in the same cycle as the starvation condition, grant the host and leave ctrl_gnt_o=0; the controller retries on the following cycle with an unchanged address.
REQ-027 SHALL make a host write followed by a read of the same address on the next cycle return the newly written data.
REQ-028 SHALL use no combinational path from sram_rdata_i to any gnt output.

Reset
REQ-029 SHALL, on rst_ni=0, asynchronously clear host_wait_cnt and the tag (to NONE), so that all outputs read zero.
REQ-030 SHALL, on reset asserted mid-access, drop the pending response: no rvalid is emitted after reset is released.
REQ-031 SHALL hold all outputs at zero in the first cycle after reset when no requests are present.

Verification
REQ-032 SHALL cover controller burst: ctrl_req_i=1 for 4 cycles at addresses 0x10..0x13 with host idle -> ctrl_gnt_o=1 for 4 cycles, then ctrl_rvalid_o=1 for 4 cycles each delayed by 1 cycle, with rdata equal to preloaded words 0x10..0x13.
REQ-033 SHALL cover starvation: ctrl_req_i=1 and host_req_i=1 held continuously with HOST_WAIT_MAX=4 -> host_gnt_o=1 in cycle 5, and on every 5th cycle thereafter; controller granted in all other cycles.
REQ-034 SHALL cover host write-then-read: write 0xA5A5 to address 3, then read address 3 on the next cycle -> host_rvalid_o on both accesses; host_rdata_o = 0 on the write response and 0xA5A5 on the read response.
REQ-035 SHALL cover host-only traffic: host_req_i=1 with ctrl_req_i=0 -> immediate host grant every cycle and host_wait_cnt stays 0.
REQ-036 SHALL cover reset mid-access: rst_ni pulled low in the cycle after ctrl_gnt_o -> ctrl_rvalid_o=0 and no response after release.
REQ-037 SHALL cover grant exclusivity: an assertion over random traffic checks that the two gnt outputs are never high together and that every gnt is matched by exactly one rvalid 1 cycle later.
